spectral_mac_pipe: RTL and testbench

- Parametrised successor to the fixed three-channel spectral recovery multiply-add.
- Computes, per spectral bin b, out[b] = sat(round((sum over c of pixel[c]*coef[c][b]) >> SHIFT)) for NCHAN pixel channels and NBINS bins.
- Systolic pipeline with one channel product per stage, followed by a round/saturate stage.
- Supports valid/ready backpressure, a per-output saturation flag and a busy indicator. Sits between the pixel source and the spectrum writer.

---
 rtl/spectral_mac_pipe_if.sv | 26 ++
 rtl/spectral_mac_pipe.sv | 94 +++++++++
 tb/tb_spectral_mac_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spectral_mac_pipe_if.sv
// spectral_mac_pipe_if: pixel-in / spectrum-out bus of the spectral multiply-add pipeline
interface spectral_mac_pipe_if #(
  parameter int NCHAN = 3,
  parameter int NBINS = 1024,
  parameter int WIDTHPIX = 8,
  parameter int WIDTHCOEF = 16,
  parameter int OUTWIDTH = 47
);
  logic valid_in;
  logic in_ready;
  logic [NCHAN-1:0][WIDTHPIX-1:0] pixel;
  logic [NCHAN-1:0][NBINS-1:0][WIDTHCOEF-1:0] coef;
  logic valid_out;
  logic ready_in;
  logic [NBINS-1:0][OUTWIDTH-1:0] spectrum;
  logic sat_flag;
  logic busy;
  modport master (
    output valid_in, pixel, coef, ready_in,
    input in_ready, valid_out, spectrum, sat_flag, busy
  );
  modport slave (
    input valid_in, pixel, coef, ready_in,
    output in_ready, valid_out, spectrum, sat_flag, busy
  );
endinterface

// File: rtl/spectral_mac_pipe.sv
// spectral_mac_pipe: systolic per-channel multiply-accumulate over all bins, then round/saturate
module spectral_mac_pipe #(
  parameter int NCHAN = 3,
  parameter int NBINS = 1024,
  parameter int WIDTHPIX = 8,
  parameter int WIDTHCOEF = 16,
  parameter int SHIFT = 0,
  parameter int OUTWIDTH = 47
) (
  input logic clk,
  input logic rst,
  spectral_mac_pipe_if.slave bus
);
  localparam int ACCW = WIDTHPIX + WIDTHCOEF + $clog2(NCHAN) + 1;
  localparam int RW = (OUTWIDTH > ACCW ? OUTWIDTH : ACCW) + 2;
  localparam int HS = SHIFT > 0 ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] HALF = SHIFT > 0 ? RW'(1) << HS : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUTWIDTH+1){1'b0}}, {(OUTWIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  logic adv;
  logic accept;
  logic [NCHAN-1:0] v_q, v_d;
  logic signed [ACCW-1:0] acc_q [NCHAN][NBINS];
  logic signed [ACCW-1:0] acc_d [NCHAN][NBINS];
  logic [NCHAN-1:0][WIDTHPIX-1:0] pd;
  logic [NBINS-1:0][OUTWIDTH-1:0] spec_q, spec_d;
  logic [NBINS-1:0] hi, lo;
  logic sat_q, sat_d;
  logic vo_q;
  assign adv = bus.ready_in | ~vo_q;
  assign accept = bus.valid_in & adv;
  assign bus.in_ready = adv;
  assign bus.valid_out = vo_q;
  assign bus.spectrum = spec_q;
  assign bus.sat_flag = sat_q;
  assign bus.busy = |v_q | vo_q;
  assign pd[0] = bus.pixel[0];
  // Channel c is delayed c cycles so it meets its accumulator at stage c+1
  for (genvar c = 1; c < NCHAN; c++) begin : g_skew
    logic [WIDTHPIX-1:0] sk_q [c];
    logic [WIDTHPIX-1:0] sk_d [c];
    // Shift the skew chain by one position
    always_comb begin
      sk_d[0] = bus.pixel[c];
      for (int d = 1; d < c; d++) sk_d[d] = sk_q[d-1];
    end
    // Skew registers advance in lockstep with the pipeline
    always_ff @(posedge clk)
      if (rst) sk_q <= '{default: '0};
      else if (adv) sk_q <= sk_d;
    assign pd[c] = sk_q[c-1];
  end
  // One channel product per stage, added onto the previous stage's partial sum
  for (genvar s = 0; s < NCHAN; s++) begin : g_stage
    for (genvar b = 0; b < NBINS; b++) begin : g_bin
      logic signed [ACCW-1:0] p;
      assign p = ACCW'($signed(pd[s])) * ACCW'($signed(bus.coef[s][b]));
      if (s == 0) begin : g_first
        assign acc_d[s][b] = p;
      end else begin : g_add
        assign acc_d[s][b] = acc_q[s-1][b] + p;
      end
    end
  end
  // Round half toward +inf, then clamp to the output range
  for (genvar b = 0; b < NBINS; b++) begin : g_out
    logic signed [RW-1:0] r;
    assign r = (RW'(acc_q[NCHAN-1][b]) + HALF) >>> SHIFT;
    assign hi[b] = r > MAXV;
    assign lo[b] = r < MINV;
    assign spec_d[b] = hi[b] ? MAXV[OUTWIDTH-1:0] : lo[b] ? MINV[OUTWIDTH-1:0] : r[OUTWIDTH-1:0];
  end
  assign sat_d = |(hi | lo);
  // Valid bits follow their data one stage per advance
  always_comb begin
    v_d[0] = accept;
    for (int i = 1; i < NCHAN; i++) v_d[i] = v_q[i-1];
  end
  // Whole pipeline advances together or holds together
  always_ff @(posedge clk)
    if (rst) begin
      v_q <= '0;
      acc_q <= '{default: '0};
      spec_q <= '0;
      sat_q <= 1'b0;
      vo_q <= 1'b0;
    end else if (adv) begin
      v_q <= v_d;
      acc_q <= acc_d;
      spec_q <= spec_d;
      sat_q <= sat_d;
      vo_q <= v_q[NCHAN-1];
    end
endmodule

// File: tb/tb_spectral_mac_pipe.sv
// tb_spectral_mac_pipe: directed vectors with a scoreboard-checked output stream
module tb_spectral_mac_pipe;
  localparam int NCHAN = 3, NBINS = 4, WP = 8, WC = 16, SHIFT = 4, OW = 16;
  typedef struct packed { logic [NBINS-1:0][OW-1:0] spec; logic sat; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int errors = 0, checks = 0, outs = 0;
  always #5 clk = ~clk;
  spectral_mac_pipe_if #(.NCHAN(NCHAN), .NBINS(NBINS), .WIDTHPIX(WP), .WIDTHCOEF(WC), .OUTWIDTH(OW)) bus ();
  spectral_mac_pipe #(.NCHAN(NCHAN), .NBINS(NBINS), .WIDTHPIX(WP), .WIDTHCOEF(WC), .SHIFT(SHIFT), .OUTWIDTH(OW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  function automatic exp_t mk(int a, int b, int c, int d, logic s);
    exp_t e;
    e.spec[0] = OW'(a);
    e.spec[1] = OW'(b);
    e.spec[2] = OW'(c);
    e.spec[3] = OW'(d);
    e.sat = s;
    return e;
  endfunction
  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
      exp_t got, e;
      got = {bus.spectrum, bus.sat_flag};
      outs++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", got);
      end else begin
        e = sb.pop_front();
        chk("scoreboard", 80'(got), 80'(e));
      end
    end
  task automatic send(int p0, int p1, int p2, exp_t e);
    bit ok;
    ok = 0;
    bus.pixel[0] = WP'(p0);
    bus.pixel[1] = WP'(p1);
    bus.pixel[2] = WP'(p2);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
    end
    if (ok) sb.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
    #1 bus.valid_in = 1'b0;
  endtask
  task automatic lat(int p0, int p1, int p2, exp_t e);
    send(p0, p1, p2, e);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("latency_valid", 80'(bus.valid_out), 80'(i == 4));
      chk("latency_busy", 80'(bus.busy), 80'(i <= 4));
    end
  endtask
  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set_coef(int c, int b0, int b1, int b2, int b3);
    bus.coef[c][0] = WC'(b0);
    bus.coef[c][1] = WC'(b1);
    bus.coef[c][2] = WC'(b2);
    bus.coef[c][3] = WC'(b3);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.pixel = '0;
    bus.coef = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 80'(bus.valid_out), 80'(0));
    chk("reset_spectrum", 80'(bus.spectrum), 80'(0));
    chk("reset_sat", 80'(bus.sat_flag), 80'(0));
    chk("reset_busy", 80'(bus.busy), 80'(0));
    chk("reset_in_ready", 80'(bus.in_ready), 80'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 80'(bus.in_ready), 80'(1));
    chk("post_reset_valid", 80'(bus.valid_out), 80'(0));
    bus.ready_in = 1'b1;
    // single vector: (10,20,30) against four bins
    @(posedge clk);
    #1;
    set_coef(0, 1, 0, -1, 100);
    set_coef(1, 2, 0, -1, 0);
    set_coef(2, 3, 0, -1, 0);
    lat(10, 20, 30, mk(9, 0, -4, 63, 0));
    wait_idle();
    // streaming: channel 0 weight 16 recovers k on every bin
    set_coef(0, 16, 16, 16, 16);
    set_coef(1, 0, 0, 0, 0);
    set_coef(2, 0, 0, 0, 0);
    fork
      for (int k = 0; k < 8; k++) send(k, 0, 0, mk(k, k, k, k, 0));
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = bus.valid_out;
        end
        chk("stream_start", 80'(seen), 80'(1));
        for (int i = 1; i < 8; i++) begin
          @(negedge clk);
          chk("stream_contiguous", 80'(bus.valid_out), 80'(1));
        end
      end
    join
    wait_idle();
    // backpressure: downstream stalls for three cycles mid-stream
    fork
      for (int k = 8; k < 16; k++) send(k, 0, 0, mk(k, k, k, k, 0));
      begin
        bit seen;
        exp_t snap;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = bus.valid_out;
        end
        chk("bp_start", 80'(seen), 80'(1));
        @(posedge clk);
        #2 bus.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (i == 0) snap = {bus.spectrum, bus.sat_flag};
          else chk("bp_hold", 80'({bus.spectrum, bus.sat_flag}), 80'(snap));
          chk("bp_in_ready", 80'(bus.in_ready), 80'(0));
          chk("bp_valid", 80'(bus.valid_out), 80'(1));
        end
        @(posedge clk);
        #2 bus.ready_in = 1'b1;
      end
    join
    wait_idle();
    chk("bp_drained", 80'(sb.size()), 80'(0));
    chk("bp_out_count", 80'(outs), 80'(17));
    // saturation in both directions
    set_coef(0, 32767, 32767, 32767, 32767);
    set_coef(1, 32767, 32767, 32767, 32767);
    set_coef(2, 32767, 32767, 32767, 32767);
    send(127, 127, 127, mk(32767, 32767, 32767, 32767, 1));
    send(-128, -128, -128, mk(-32768, -32768, -32768, -32768, 1));
    wait_idle();
    // rounding: sums -8, -16, +8, 0
    set_coef(0, 1, 2, -1, 0);
    set_coef(1, 0, 0, 0, 0);
    set_coef(2, 0, 0, 0, 0);
    send(-8, 0, 0, mk(0, -1, 1, 0, 0));
    wait_idle();
    // reset with two vectors in flight
    send(1, 0, 0, mk(0, 0, 0, 0, 0));
    send(2, 0, 0, mk(0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_valid", 80'(bus.valid_out), 80'(0));
      chk("flush_busy", 80'(bus.busy), 80'(0));
    end
    @(posedge clk);
    #1;
    lat(16, 0, 0, mk(1, 2, -1, 0, 0));
    wait_idle();
    chk("final_drained", 80'(sb.size()), 80'(0));
    chk("final_out_count", 80'(outs), 80'(21));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
